// File: rtl/nvdla_hls_staller_pkg.sv
// Shared types and helpers for the multi-channel HLS core staller.
package nvdla_hls_staller_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HUNG  = 2'd2
  } stall_state_e;

  localparam logic [1:0] STATE_RUN   = 2'd0;
  localparam logic [1:0] STATE_STALL = 2'd1;
  localparam logic [1:0] STATE_HUNG  = 2'd2;

  // Width needed to hold 0..limit; a disabled watchdog (limit 0) still gets one bit.
  function automatic int run_stall_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/nvdla_hls_sat_cnt.sv
// Up-counter that sticks at MAX instead of wrapping; clr overrides inc.
module nvdla_hls_sat_cnt
  import nvdla_hls_staller_pkg::*;
#(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count up on inc until MAX is reached; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/nvdla_hls_core_staller_nch.sv
// Multi-channel core staller: combines channel completion flags into the core
// write enable, and tracks stall statistics, stall causes and a watchdog.
module nvdla_hls_core_staller_nch
  import nvdla_hls_staller_pkg::*;
#(
  parameter int NUM_IN     = 1,
  parameter int NUM_OUT    = 1,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic [NUM_IN-1:0]  chn_in_wen_comp,
  input  logic [NUM_OUT-1:0] chn_out_wen_comp,
  input  logic               stall_force,
  input  logic               stat_clr,
  output logic               core_wen,
  output logic               core_wten,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [NUM_IN-1:0]  stall_in_mask,
  output logic [NUM_OUT-1:0] stall_out_mask,
  output logic [1:0]         stall_state,
  output logic               wdog_trip
);

  localparam int              RS_W   = run_stall_w(WDOG_LIMIT);
  localparam logic [RS_W-1:0] RS_MAX = RS_W'(WDOG_LIMIT);

  logic              w_core_wen;
  logic              w_stall;
  logic              w_trip;
  logic [RS_W-1:0]   w_run_stall;
  stall_state_e      r_state;
  stall_state_e      w_state_nxt;
  logic              r_wten;
  logic              r_wdog_trip;
  logic [NUM_IN-1:0]  r_in_mask;
  logic [NUM_OUT-1:0] r_out_mask;

  assign w_core_wen = (&chn_in_wen_comp) & (&chn_out_wen_comp) & ~stall_force;
  assign w_stall    = ~w_core_wen;

  // Total stalled cycles, saturating at all-ones.
  nvdla_hls_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .inc (w_stall),
    .clr (stat_clr),
    .cnt (stall_cnt)
  );

  // Consecutive stalled cycles; any advancing cycle restarts the run.
  nvdla_hls_sat_cnt #(.W(RS_W), .MAX(RS_MAX)) u_run_stall (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .inc (w_stall),
    .clr (stat_clr | w_core_wen),
    .cnt (w_run_stall)
  );

  // This stalled cycle completes the WDOG_LIMIT-th in a row.
  assign w_trip = (WDOG_LIMIT != 0) && w_stall &&
                  ((int'(w_run_stall) + 1) == WDOG_LIMIT);

  // Next-state decode; stat_clr always forces RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_stall) w_state_nxt = w_trip ? ST_HUNG : ST_STALL;
      ST_STALL: begin
        if (w_core_wen)  w_state_nxt = ST_RUN;
        else if (w_trip) w_state_nxt = ST_HUNG;
      end
      ST_HUNG:  if (w_core_wen) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
    if (stat_clr) w_state_nxt = ST_RUN;
  end

  // State register.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) r_state <= ST_RUN;
    else                r_state <= w_state_nxt;
  end

  // Sticky watchdog flag, only cleared by stat_clr or reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst)  r_wdog_trip <= 1'b0;
    else if (stat_clr)   r_wdog_trip <= 1'b0;
    else if (w_trip)     r_wdog_trip <= 1'b1;
  end

  // Accumulate the channels that were not ready during stalled cycles.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_in_mask  <= '0;
      r_out_mask <= '0;
    end else if (stat_clr) begin
      r_in_mask  <= '0;
      r_out_mask <= '0;
    end else if (w_stall) begin
      r_in_mask  <= r_in_mask  | ~chn_in_wen_comp;
      r_out_mask <= r_out_mask | ~chn_out_wen_comp;
    end
  end

  // Registered wait-enable companion of core_wen.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) r_wten <= 1'b0;
    else                r_wten <= w_stall;
  end

  assign core_wen       = w_core_wen;
  assign core_wten      = r_wten;
  assign stall_in_mask  = r_in_mask;
  assign stall_out_mask = r_out_mask;
  assign stall_state    = r_state;
  assign wdog_trip      = r_wdog_trip;

endmodule

// File: tb/tb_nvdla_hls_core_staller_nch.sv
// Scoreboard bench for nvdla_hls_core_staller_nch (NUM_IN=2, NUM_OUT=1,
// CNT_W=3, WDOG_LIMIT=4) with a behavioural reference model.
module tb_nvdla_hls_core_staller_nch;

  localparam int NI  = 2;
  localparam int NO  = 1;
  localparam int CW  = 3;
  localparam int LIM = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] in_comp;
  logic [NO-1:0] out_comp;
  logic          force_st;
  logic          clr;
  logic          core_wen;
  logic          core_wten;
  logic [CW-1:0] stall_cnt;
  logic [NI-1:0] in_mask;
  logic [NO-1:0] out_mask;
  logic [1:0]    st;
  logic          trip;

  nvdla_hls_core_staller_nch #(
    .NUM_IN(NI), .NUM_OUT(NO), .CNT_W(CW), .WDOG_LIMIT(LIM)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .chn_in_wen_comp  (in_comp),
    .chn_out_wen_comp (out_comp),
    .stall_force      (force_st),
    .stat_clr         (clr),
    .core_wen         (core_wen),
    .core_wten        (core_wten),
    .stall_cnt        (stall_cnt),
    .stall_in_mask    (in_mask),
    .stall_out_mask   (out_mask),
    .stall_state      (st),
    .wdog_trip        (trip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          chk_regs;
    logic          wen;
    logic          wten;
    logic [CW-1:0] cnt;
    logic [NI-1:0] inm;
    logic [NO-1:0] outm;
    logic [1:0]    state;
    logic          trip;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: statistics as plain integers, "hung" meaning the current
  // run of consecutive stalls has reached the watchdog limit.
  int          m_cnt = 0;
  int          m_consec = 0;
  logic [NI-1:0] m_inm = '0;
  logic [NO-1:0] m_outm = '0;
  logic        m_hung = 1'b0;
  logic        m_trip = 1'b0;
  logic        m_wten = 1'b0;
  logic [1:0]  m_state = 2'd0;
  logic        m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    else             n_pass++;
  endtask

  // One clock cycle of stimulus: drive, record the expectation, advance the model.
  task automatic step(input logic [NI-1:0] i_in, input logic [NO-1:0] i_out,
                      input logic i_force, input logic i_clr, input logic i_rst);
    exp_t e;
    logic wen;
    @(posedge clk);
    #1;
    in_comp = i_in; out_comp = i_out; force_st = i_force; clr = i_clr; rst = i_rst;
    wen = (i_in == '1) && (i_out == '1) && !i_force;
    e.chk_regs = m_valid;
    e.wen = wen; e.wten = m_wten; e.cnt = CW'(m_cnt); e.inm = m_inm; e.outm = m_outm;
    e.state = m_state; e.trip = m_trip;
    exp_q.push_back(e);
    if (i_rst) begin
      m_cnt = 0; m_consec = 0; m_inm = '0; m_outm = '0;
      m_hung = 0; m_trip = 0; m_wten = 0; m_state = 2'd0;
      m_valid = 1'b1;
    end else begin
      m_wten = !wen;
      if (i_clr) begin
        m_cnt = 0; m_consec = 0; m_inm = '0; m_outm = '0; m_hung = 0; m_trip = 0;
        m_state = 2'd0;
      end else if (!wen) begin
        m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        m_inm    = m_inm | ~i_in;
        m_outm   = m_outm | ~i_out;
        m_consec = (m_consec < LIM) ? m_consec + 1 : LIM;
        if (LIM != 0 && m_consec == LIM) begin
          m_hung = 1'b1;
          m_trip = 1'b1;
        end
        m_state = m_hung ? 2'd2 : 2'd1;
      end else begin
        m_consec = 0;
        m_hung   = 1'b0;
        m_state  = 2'd0;
      end
    end
  endtask

  task automatic repeat_step(input int n, input logic [NI-1:0] i_in, input logic [NO-1:0] i_out,
                             input logic i_force, input logic i_clr);
    for (int k = 0; k < n; k++) step(i_in, i_out, i_force, i_clr, 1'b0);
  endtask

  // Monitor: on every falling edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("core_wen", 32'(core_wen), 32'(e.wen));
        if (e.chk_regs) begin
          chk("core_wten", 32'(core_wten), 32'(e.wten));
          chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
          chk("stall_in_mask", 32'(in_mask), 32'(e.inm));
          chk("stall_out_mask", 32'(out_mask), 32'(e.outm));
          chk("stall_state", 32'(st), 32'(e.state));
          chk("wdog_trip", 32'(trip), 32'(e.trip));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NI-1:0] ri;
    logic [NO-1:0] ro;
    logic          rf, rc, rr;
    int            len;
    rst = 1'b1; in_comp = '1; out_comp = '1; force_st = 1'b0; clr = 1'b0;

    step(2'b11, 1'b1, 0, 0, 1);
    step(2'b11, 1'b1, 0, 0, 1);
    // Idle with every channel ready.
    repeat_step(10, 2'b11, 1'b1, 0, 0);
    // Input channel 1 not ready for three cycles.
    repeat_step(3, 2'b01, 1'b1, 0, 0);
    repeat_step(3, 2'b11, 1'b1, 0, 0);
    // Debug force-stall alone.
    step(2'b11, 1'b1, 0, 1, 0);
    repeat_step(5, 2'b11, 1'b1, 1, 0);
    repeat_step(2, 2'b11, 1'b1, 0, 0);
    // Watchdog: output channel held off for six cycles, then released.
    step(2'b11, 1'b1, 0, 1, 0);
    repeat_step(6, 2'b11, 1'b0, 0, 0);
    repeat_step(3, 2'b11, 1'b1, 0, 0);
    // Counter saturation, then a clear during a stalled cycle.
    step(2'b11, 1'b1, 0, 1, 0);
    repeat_step(10, 2'b00, 1'b1, 0, 0);
    step(2'b00, 1'b0, 0, 1, 0);
    repeat_step(2, 2'b11, 1'b1, 0, 0);
    // Reset while hung, with inputs still not all ready.
    repeat_step(5, 2'b11, 1'b0, 0, 0);
    step(2'b10, 1'b1, 0, 0, 1);
    step(2'b10, 1'b1, 0, 0, 0);
    repeat_step(2, 2'b11, 1'b1, 0, 0);

    // Randomized bursts: each pattern held for a random length.
    for (int b = 0; b < 150; b++) begin
      ri  = NI'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) ri = '1;
      ro  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      rf  = ($urandom_range(0, 7) == 0);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        rc = ($urandom_range(0, 31) == 0);
        rr = ($urandom_range(0, 127) == 0);
        step(ri, ro, rf, rc, rr);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
